vga_plot_scheduler: RTL and testbench
=====================================

# vga_plot_scheduler

Arbitrates and sequences pixel writes into the 160x120 `vga_adapter` for three requesters: tail erase, snake-head draw and food draw. Each accepted request becomes one 4x4 block write, issued as 16 single-pixel `plot` cycles in raster order. The block sits between the snake control FSM / food logic and the adapter's `x`/`y`/`colour`/`plot` inputs, and it is the only driver of those inputs.

## Interface

Parameters:

- `X_MAX`, default 159: largest legal pixel x. Pixels with x above this are suppressed.
- `Y_MAX`, default 119: largest legal pixel y. Pixels with y above this are suppressed.

Ports:

- `clk` input 1: system clock (CLOCK_50 domain).
- `resetn` input 1: reset, asynchronous, active-low.
- `req_erase` input 1: request to erase a block; colour is forced to 3'b000.
- `erase_x` input 8: base x of the erase block.
- `erase_y` input 7: base y of the erase block.
- `req_head` input 1: request to draw the head block.
- `head_x` input 8, `head_y` input 7, `head_c` input 3: base coordinates and colour of the head block.
- `req_food` input 1: request to draw the food block.
- `food_x` input 8, `food_y` input 7, `food_c` input 3: base coordinates and colour of the food block.
- `ack_erase`, `ack_head`, `ack_food` output 1 each: one-cycle pulse; the job was latched.
- `done_erase`, `done_head`, `done_food` output 1 each: one-cycle pulse during that job's last pixel cycle.
- `busy` output 1: high while a job is in progress.
- `x_out` output 8, `y_out` output 7, `c_out` output 3, `plot` output 1: connect to the adapter's `x`, `y`, `colour` and `plot`.

## Operation

- State machine has two states, IDLE and DRAW. Reset enters IDLE.
- **IDLE:**
  - Sample the `req_*` inputs on every clock edge.
  - If any request is high, latch that requester's base x, base y and colour into job registers. Colour is 3'b000 for an erase job.
  - On the same edge, clear the pixel counter `cnt` (4 bits) to 0, go to DRAW, and set the matching `ack_*` high for the next cycle only.
  - If no request is high, stay in IDLE.
- **Priority:** fixed, erase > head > food. A losing request that is still high is served at the next IDLE. Requesters hold `req` until they see `ack`, and drop it in the cycle after `ack` unless they want another job.
- **DRAW:**
  - Pixel coordinates are computed at 9 bits for x and 8 bits for y: `px = bx + cnt[1:0]`, `py = by + cnt[3:2]`.
  - `x_out = px[7:0]`, `y_out = py[6:0]`, `c_out` = latched colour.
  - `plot = 1` only when `px <= X_MAX` and `py <= Y_MAX`. Otherwise the pixel is skipped but `cnt` still advances, so a clipped job always takes 16 cycles.
  - `cnt` increments on every edge in DRAW.
  - When `cnt == 15`, the matching `done_*` is high that cycle, and the next edge returns to IDLE.
- **IDLE outputs:** `plot = 0`, `x_out = 0`, `y_out = 0`, `c_out = 0`, `busy = 0`.
- **Request inputs during DRAW** are ignored. Base, colour and requester are frozen until the job ends.
- **Reset (asynchronous, any cycle, including mid-job):**
  - State goes to IDLE, `cnt` to 0, job registers to 0, and all `ack_*` / `done_*` to 0.
  - `plot` drops to 0 immediately, without waiting for a clock.
  - A partially drawn block is abandoned and never resumed.

## Timing

- Request latency: request high before edge k (state IDLE) gives `ack` and `busy` in cycle k+1. The first pixel (`cnt = 0`) is also output in cycle k+1.
- Job length: 16 DRAW cycles, followed by at least one IDLE cycle. The minimum repeat period per job is 17 cycles.
- `done_*` and the final pixel (`cnt = 15`, offset (3,3)) share the same cycle.
- All outputs are functions of registered state. There is no combinational path from `req_*` to the outputs.
- Raster order within a block is offsets (0,0),(1,0),(2,0),(3,0),(0,1), … ,(3,3).

## Test plan

- **Single head job:** `req_head = 1`, head at (10,20), `head_c = 3'b010`.
  - Required: `ack_head` in the next cycle, then 16 `plot` cycles covering x 10..13, y 20..23 in raster order with `c_out = 010`.
  - `done_head` on the 16th cycle, then `busy = 0`.
- **Simultaneous requests:** all three requests in the same cycle, each held until its own ack.
  - Required: erase served first, then head, then food.
  - Acks arrive at cycles 1, 18 and 35 after the request cycle.
  - All erase pixels have `c_out = 000`, even when the other colour inputs are 3'b111.
- **Clipping:** head at (158,118).
  - Required: exactly 4 `plot` pulses, at (158,118), (159,118), (158,119), (159,119).
  - The job still lasts 16 cycles, and `done_head` arrives on the 16th.
- **Reset mid-job:** assert `resetn = 0` after the 5th pixel of a food job.
  - Required: `plot`, `busy` and `x_out` are 0 before the next edge.
  - After release, the block stays in IDLE with no `done_food`.
  - A new request is served normally from `cnt = 0`.
- **Back-to-back jobs:** `req_food` held high continuously.
  - Required: `ack_food` every 17 cycles, with exactly one IDLE cycle (`plot = 0`) between blocks.
- **Request arriving mid-job:** `req_erase` pulsed for one cycle during a head job's DRAW.
  - Required: the pulse is ignored, with no `ack_erase`. The head job completes unchanged.

Source files
------------

// File: rtl/vga_plot_scheduler.sv
// Pixel-write scheduler for the 160x120 vga_adapter: arbitrates erase/head/food
// requests (fixed priority) and expands each into a 16-cycle 4x4 raster block write.
module vga_plot_scheduler #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_erase,
  input  logic [7:0] erase_x,
  input  logic [6:0] erase_y,
  input  logic       req_head,
  input  logic [7:0] head_x,
  input  logic [6:0] head_y,
  input  logic [2:0] head_c,
  input  logic       req_food,
  input  logic [7:0] food_x,
  input  logic [6:0] food_y,
  input  logic [2:0] food_c,
  output logic       ack_erase,
  output logic       ack_head,
  output logic       ack_food,
  output logic       done_erase,
  output logic       done_head,
  output logic       done_food,
  output logic       busy,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] c_out,
  output logic       plot
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_ERASE = 2'd0,
    SRC_HEAD  = 2'd1,
    SRC_FOOD  = 2'd2
  } src_e;

  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  state_e     state_q, state_d;
  src_e       src_q,   src_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [7:0] bx_q,    bx_d;
  logic [6:0] by_q,    by_d;
  logic [2:0] col_q,   col_d;
  logic [2:0] ack_q,   ack_d;   // {food, head, erase}

  logic [8:0] px;
  logic [7:0] py;
  logic       last_pixel;

  // State register. Reset clears the whole job context so an interrupted
  // block is abandoned rather than resumed.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would create races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= SRC_ERASE;
      cnt_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      col_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state and job-latch logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned -- that is what keeps always_comb from inferring a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    col_d   = col_q;
    ack_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_erase) begin
          src_d = SRC_ERASE;
          bx_d  = erase_x;
          by_d  = erase_y;
          col_d = 3'b000;
          ack_d = 3'b001;
        end else if (req_head) begin
          src_d = SRC_HEAD;
          bx_d  = head_x;
          by_d  = head_y;
          col_d = head_c;
          ack_d = 3'b010;
        end else if (req_food) begin
          src_d = SRC_FOOD;
          bx_d  = food_x;
          by_d  = food_y;
          col_d = food_c;
          ack_d = 3'b100;
        end

        if (req_erase || req_head || req_food) begin
          state_d = S_DRAW;
          cnt_d   = '0;
        end
      end

      S_DRAW: begin
        // Counter wraps 15 -> 0 on the exit edge, leaving IDLE with cnt = 0.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pixel address is widened by one bit so off-screen pixels are detected
  // instead of wrapping back onto the visible area.
  assign px         = {1'b0, bx_q} + {7'b0, cnt_q[1:0]};
  assign py         = {1'b0, by_q} + {6'b0, cnt_q[3:2]};
  assign last_pixel = (cnt_q == 4'd15);

  // Output decode from registered state only.
  always_comb begin
    busy       = 1'b0;
    plot       = 1'b0;
    x_out      = '0;
    y_out      = '0;
    c_out      = '0;
    done_erase = 1'b0;
    done_head  = 1'b0;
    done_food  = 1'b0;

    if (state_q == S_DRAW) begin
      busy       = 1'b1;
      x_out      = px[7:0];
      y_out      = py[6:0];
      c_out      = col_q;
      plot       = (px <= X_LIM) && (py <= Y_LIM);
      done_erase = last_pixel && (src_q == SRC_ERASE);
      done_head  = last_pixel && (src_q == SRC_HEAD);
      done_food  = last_pixel && (src_q == SRC_FOOD);
    end
  end

  assign ack_erase = ack_q[0];
  assign ack_head  = ack_q[1];
  assign ack_food  = ack_q[2];

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Scoreboard bench for vga_plot_scheduler: stimulus queues expected pixel,
// ack and done events tagged with their cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_plot_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_erase, req_head, req_food;
  logic [7:0] erase_x, head_x, food_x;
  logic [6:0] erase_y, head_y, food_y;
  logic [2:0] head_c, food_c;
  logic       ack_erase, ack_head, ack_food;
  logic       done_erase, done_head, done_food;
  logic       busy, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] c_out;

  vga_plot_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_erase  (req_erase),
    .erase_x    (erase_x),
    .erase_y    (erase_y),
    .req_head   (req_head),
    .head_x     (head_x),
    .head_y     (head_y),
    .head_c     (head_c),
    .req_food   (req_food),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_c     (food_c),
    .ack_erase  (ack_erase),
    .ack_head   (ack_head),
    .ack_food   (ack_food),
    .done_erase (done_erase),
    .done_head  (done_head),
    .done_food  (done_food),
    .busy       (busy),
    .x_out      (x_out),
    .y_out      (y_out),
    .c_out      (c_out),
    .plot       (plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int cyc;
    int id;   // 0 erase, 1 head, 2 food
  } evt_t;

  pix_t pix_q[$];
  evt_t exp_ack_q[$];
  evt_t exp_done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
  endtask

  // Expected events for one 4x4 job whose ack (and first pixel) lands in cycle cs.
  task automatic push_job(input int id, input int cs, input int bx, input int by,
                          input logic [2:0] c);
    for (int k = 0; k < 16; k++) begin
      int px = bx + (k % 4);
      int py = by + (k / 4);
      if (px <= 159 && py <= 119)
        pix_q.push_back('{cyc: cs + k, x: 8'(px), y: 7'(py), c: c});
    end
    exp_ack_q.push_back('{cyc: cs, id: id});
    exp_done_q.push_back('{cyc: cs + 15, id: id});
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  pix_t       mp;
  evt_t       me;
  logic [2:0] ack_vec, done_vec;

  always @(negedge clk) begin
    if (resetn) begin
      ack_vec  = {ack_food, ack_head, ack_erase};
      done_vec = {done_food, done_head, done_erase};
      if (plot) begin
        if (pix_q.size() == 0) unexpected("plot");
        else begin
          mp = pix_q.pop_front();
          check("pixel{cyc,x,y,c}", {32'(cyc), x_out, y_out, c_out},
                {32'(mp.cyc), mp.x, mp.y, mp.c});
        end
      end
      if (ack_vec != 3'b000) begin
        if (exp_ack_q.size() == 0) unexpected("ack");
        else begin
          me = exp_ack_q.pop_front();
          check("ack{cyc,vec}", {32'(cyc), ack_vec}, {32'(me.cyc), 3'b001 << me.id});
        end
      end
      if (done_vec != 3'b000) begin
        if (exp_done_q.size() == 0) unexpected("done");
        else begin
          me = exp_done_q.pop_front();
          check("done{cyc,vec}", {32'(cyc), done_vec}, {32'(me.cyc), 3'b001 << me.id});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int n = 0;
    while ((pix_q.size() + exp_ack_q.size() + exp_done_q.size()) > 0 && n < 300) begin
      step();
      n++;
    end
    check({name, "_pix_left"},  64'(pix_q.size()), 0);
    check({name, "_ack_left"},  64'(exp_ack_q.size()), 0);
    check({name, "_done_left"}, 64'(exp_done_q.size()), 0);
    step();
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_idle_plot"}, plot, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    resetn    = 1'b0;
    req_erase = 0; req_head = 0; req_food = 0;
    erase_x = 0; erase_y = 0;
    head_x = 0; head_y = 0; head_c = 0;
    food_x = 0; food_y = 0; food_c = 0;

    // Reset state
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_plot", plot, 1'b0);
    check("rst_xyc", {x_out, y_out, c_out}, 18'd0);
    check("rst_ack", {ack_food, ack_head, ack_erase}, 3'b000);
    check("rst_done", {done_food, done_head, done_erase}, 3'b000);
    resetn = 1'b1;
    step();

    // Single head job at (10,20), colour 010
    c0 = cyc;
    head_x = 8'd10; head_y = 7'd20; head_c = 3'b010; req_head = 1;
    push_job(1, c0 + 1, 10, 20, 3'b010);
    step();
    req_head = 0;
    drain("single");

    // Simultaneous requests: erase, then head, then food
    c0 = cyc;
    erase_x = 8'd5;  erase_y = 7'd6;
    head_x  = 8'd7;  head_y  = 7'd8;  head_c = 3'b111;
    food_x  = 8'd9;  food_y  = 7'd10; food_c = 3'b111;
    req_erase = 1; req_head = 1; req_food = 1;
    push_job(0, c0 + 1,  5, 6,  3'b000);
    push_job(1, c0 + 18, 7, 8,  3'b111);
    push_job(2, c0 + 35, 9, 10, 3'b111);
    while (cyc < c0 + 35) begin
      step();
      if (cyc == c0 + 1)  req_erase = 0;
      if (cyc == c0 + 18) req_head  = 0;
    end
    req_food = 0;
    drain("simul");

    // Clipping at the bottom-right corner
    c0 = cyc;
    head_x = 8'd158; head_y = 7'd118; head_c = 3'b101; req_head = 1;
    push_job(1, c0 + 1, 158, 118, 3'b101);
    step();
    req_head = 0;
    drain("clip");

    // Reset after the 5th pixel of a food job
    c0 = cyc;
    food_x = 8'd40; food_y = 7'd50; food_c = 3'b100; req_food = 1;
    push_job(2, c0 + 1, 40, 50, 3'b100);
    step();
    req_food = 0;
    while (cyc < c0 + 5) step();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_plot", plot, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_x", x_out, 8'd0);
    pix_q.delete();
    exp_ack_q.delete();
    exp_done_q.delete();
    step();
    resetn = 1'b1;
    repeat (3) step();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", {done_food, done_head, done_erase}, 3'b000);
    c0 = cyc;
    food_x = 8'd20; food_y = 7'd30; food_c = 3'b110; req_food = 1;
    push_job(2, c0 + 1, 20, 30, 3'b110);
    step();
    req_food = 0;
    drain("post_rst");

    // Back-to-back food jobs with req_food held
    c0 = cyc;
    food_x = 8'd60; food_y = 7'd70; food_c = 3'b011; req_food = 1;
    push_job(2, c0 + 1,  60, 70, 3'b011);
    push_job(2, c0 + 18, 60, 70, 3'b011);
    push_job(2, c0 + 35, 60, 70, 3'b011);
    while (cyc < c0 + 35) begin
      step();
      if (cyc == c0 + 17 || cyc == c0 + 34) begin
        check("b2b_gap_plot", plot, 1'b0);
        check("b2b_gap_busy", busy, 1'b0);
      end
    end
    req_food = 0;
    drain("b2b");

    // Erase pulse during a head job is ignored
    c0 = cyc;
    head_x = 8'd30; head_y = 7'd40; head_c = 3'b001; req_head = 1;
    push_job(1, c0 + 1, 30, 40, 3'b001);
    step();
    req_head = 0;
    while (cyc < c0 + 5) step();
    erase_x = 8'd1; erase_y = 7'd2; req_erase = 1;
    step();
    req_erase = 0;
    drain("midjob");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
